// File: rtl/led_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with tear-free frame updates.
// Optional leading-zero blanking is compiled in when LED_SCAN_LZB_EN is defined.
module led_scan_driver #(
  parameter int DIGITS           = 8,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYC        = 16,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_bus,
  input  logic [DIGITS-1:0]     dot_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  load,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DARK_END  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   =
    (DIGIT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  localparam logic [0:0] ST_DARK = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  // Scan position
  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;

  // Frame currently on display and the frame waiting for the next boundary
  logic [4*DIGITS-1:0] act_bcd_q, act_bcd_d;
  logic [DIGITS-1:0]   act_dot_q, act_dot_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [DIGITS-1:0]   pend_dot_q, pend_dot_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_valid_q, pend_valid_d;

  // Registered pin drivers
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fs_q, fs_d;

  logic                boundary;
  logic [0:0]          slot_state;
  logic [3:0]          cur_nib;
  logic                cur_dot;
  logic                cur_blank;
  logic                cur_sup;
  logic [DIGITS-1:0]   lzb_mask;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = 8'hC0;
      4'h1: seg_encode = 8'hF9;
      4'h2: seg_encode = 8'hA4;
      4'h3: seg_encode = 8'hB0;
      4'h4: seg_encode = 8'h99;
      4'h5: seg_encode = 8'h92;
      4'h6: seg_encode = 8'h82;
      4'h7: seg_encode = 8'hF8;
      4'h8: seg_encode = 8'h80;
      4'h9: seg_encode = 8'h90;
      4'hA: seg_encode = 8'h88;
      4'hB: seg_encode = 8'h83;
      4'hC: seg_encode = 8'hC6;
      4'hD: seg_encode = 8'hA1;
      4'hE: seg_encode = 8'h86;
      default: seg_encode = 8'h8E;
    endcase
  endfunction

  assign boundary   = (slot_cnt_q == '0) && (digit_idx_q == '0);
  assign slot_state = (slot_cnt_q < DARK_END) ? ST_DARK : ST_SHOW;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin : counter_next
    slot_cnt_d  = slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  // New frames only reach the display on the boundary cycle, so a scan never mixes two frames.
  always_comb begin : frame_next
    act_bcd_d    = act_bcd_q;
    act_dot_d    = act_dot_q;
    act_blank_d  = act_blank_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dot_d   = pend_dot_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    if (boundary) begin
      if (load) begin
        act_bcd_d   = bcd_bus;
        act_dot_d   = dot_mask;
        act_blank_d = blank_mask;
      end else if (pend_valid_q) begin
        act_bcd_d   = pend_bcd_q;
        act_dot_d   = pend_dot_q;
        act_blank_d = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_bcd_d   = bcd_bus;
      pend_dot_d   = dot_mask;
      pend_blank_d = blank_mask;
      pend_valid_d = 1'b1;
    end
  end

`ifdef LED_SCAN_LZB_EN
  // Suppress zeros from the most significant digit down; digit 0 always shows.
  always_comb begin : lzb_scan
    logic leading;
    leading  = 1'b1;
    lzb_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (act_bcd_q[4*k +: 4] == 4'h0) && !act_dot_q[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin : digit_mux
    cur_nib   = 4'h0;
    cur_dot   = 1'b0;
    cur_blank = 1'b1;
    cur_sup   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx_q == IDX_W'(k)) begin
        cur_nib   = act_bcd_q[4*k +: 4];
        cur_dot   = act_dot_q[k];
        cur_blank = act_blank_q[k];
        cur_sup   = lzb_mask[k];
      end
    end
  end

  always_comb begin : output_next
    fs_d  = boundary;
    seg_d = 8'hFF;
    sel_d = SEL_OFF;
    if (slot_state == ST_SHOW) begin
      seg_d = seg_encode(cur_nib);
      if (cur_blank || cur_sup) begin
        seg_d[6:0] = 7'h7F;
      end
      seg_d[7] = ~cur_dot;
      sel_d    = (DIGITS'(1) << digit_idx_q) ^ SEL_OFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= '0;
      // NOTE: frame storage is reset because "all blanked" is the visible power-on picture.
      act_bcd_q    <= '0;
      act_dot_q    <= '0;
      act_blank_q  <= '1;
      pend_bcd_q   <= '0;
      pend_dot_q   <= '0;
      pend_blank_q <= '1;
      pend_valid_q <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= SEL_OFF;
      fs_q         <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      act_bcd_q    <= act_bcd_d;
      act_dot_q    <= act_dot_d;
      act_blank_q  <= act_blank_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dot_q   <= pend_dot_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_out     = seg_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;

endmodule
